// File: rtl/add_round_key_stage.sv
// AddRoundKey stage of an iterative AES-128 encryptor: XORs each beat with the
// current round key and expands the next round key on the fly.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic         key_valid;
    logic [3:0]   round;
    logic [127:0] rk;
    logic [127:0] key0;
    logic [127:0] next_rk;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box computed as the GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // One key-schedule step; the word holding bytes 12..15 is rotated so byte 13 leads.
    always_comb begin
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sbox(rk[103:96]), sbox(rk[127:120]), sbox(rk[119:112]),
              sbox(rk[111:104]) ^ rcon(round + 4'd1)};
        n0 = rk[31:0]   ^ t;
        n1 = rk[63:32]  ^ n0;
        n2 = rk[95:64]  ^ n1;
        n3 = rk[127:96] ^ n2;
        next_rk = {n3, n2, n1, n0};
    end

    assign in_ready = key_valid & ~key_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            round     <= 4'd0;
            rk        <= '0;
            key0      <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= 4'd0;
            out_last  <= 1'b0;
        end else if (key_load) begin
            key0      <= key_in;
            rk        <= key_in;
            round     <= 4'd0;
            key_valid <= 1'b1;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_state <= in_state ^ rk;
            out_round <= round;
            out_last  <= (round == LAST_ROUND);
            out_valid <= 1'b1;
            if (round == LAST_ROUND) begin
                round <= 4'd0;
                rk    <= key0;
            end else begin
                round <= round + 4'd1;
                rk    <= next_rk;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Self-checking bench for add_round_key_stage: FIPS-197 vectors plus a randomized
// stream compared against a table-driven key-schedule and pipeline model.
module tb_add_round_key_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    add_round_key_stage #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // Reference model state
    logic [127:0] rks [11];
    logic         m_kv, m_ov, m_ol;
    int           m_round;
    logic [3:0]   m_or;
    logic [127:0] m_os;

    function automatic logic [7:0] tb_sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    // Converts FIPS text order (first byte leftmost) into the port byte order.
    function automatic logic [127:0] fips(input logic [127:0] h);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127 - 8*i -: 8];
        return r;
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [7:0] kb [11][16];
        logic [7:0] t [4];
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) kb[0][i] = k[8*i +: 8];
        for (int r = 1; r <= 10; r++) begin
            t[0] = tb_sbox(kb[r-1][13]) ^ rc;
            t[1] = tb_sbox(kb[r-1][14]);
            t[2] = tb_sbox(kb[r-1][15]);
            t[3] = tb_sbox(kb[r-1][12]);
            for (int i = 0; i < 16; i++)
                kb[r][i] = kb[r-1][i] ^ ((i < 4) ? t[i] : kb[r][i-4]);
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        for (int r = 0; r <= 10; r++)
            for (int i = 0; i < 16; i++) rks[r][8*i +: 8] = kb[r][i];
    endtask

    task automatic model_reset();
        m_kv = 1'b0; m_ov = 1'b0; m_ol = 1'b0; m_round = 0; m_or = 4'd0; m_os = '0;
    endtask

    function automatic logic exp_ready();
        return m_kv && !key_load && (!m_ov || out_ready);
    endfunction

    // Advances one clock edge and applies the same edge to the model.
    task automatic tick();
        logic er;
        er = exp_ready();
        @(posedge clk);
        if (rst_n) begin
            if (key_load) begin
                expand_key(key_in);
                m_kv = 1'b1; m_round = 0; m_ov = 1'b0;
            end else if (in_valid && er) begin
                m_os = in_state ^ rks[m_round];
                m_or = 4'(m_round);
                m_ol = (m_round == 10);
                m_ov = 1'b1;
                m_round = (m_round == 10) ? 0 : m_round + 1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_load = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        key_in = {4{$urandom}}; in_state = {4{$urandom}};
        model_reset();
        #2;
        checks++;
        if ({out_valid, out_state, in_ready} !== 130'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b s=%h r=%b, expected all zero", out_valid, out_state, in_ready);
        end
        tick(); tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_state = {4{$urandom}};
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ready_before_key: got %b expected 0", in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL valid_before_key: got %b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_key_schedule();
        key_load = 1'b1; key_in = fips(FIPS_KEY); in_valid = 1'b0; out_ready = 1'b1;
        tick();
        key_load = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            in_valid = 1'b1; in_state = '0;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ks_ready r%0d: got %b expected 1", r, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_round, out_last, out_state} !== {m_ov, m_or, m_ol, m_os}) begin
                errors++;
                $display("[TB] FAIL ks_beat r%0d: got v=%b r=%0d l=%b s=%h expected v=%b r=%0d l=%b s=%h",
                         r, out_valid, out_round, out_last, out_state, m_ov, m_or, m_ol, m_os);
            end
            if (r == 0 || r == 1 || r == 10) begin
                logic [127:0] want;
                want = (r == 0) ? fips(FIPS_KEY) :
                       (r == 1) ? fips(128'ha0fafe1788542cb123a339392a6c7605) :
                                  fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                checks++;
                if (out_state !== want || out_last !== (r == 10)) begin
                    errors++;
                    $display("[TB] FAIL ks_vector r%0d: got %h last=%b expected %h last=%b",
                             r, out_state, out_last, want, (r == 10));
                end
            end
        end
    endtask

    task automatic test_wrap();
        in_valid = 1'b1; in_state = '0;
        tick();
        checks++;
        if ({out_valid, out_round, out_last, out_state} !== {1'b1, 4'd0, 1'b0, fips(FIPS_KEY)}) begin
            errors++;
            $display("[TB] FAIL wrap: got v=%b r=%0d l=%b s=%h expected round 0 key", out_valid, out_round, out_last, out_state);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]   held_round;
        logic [127:0] held_state;
        held_round = out_round; held_state = out_state;
        out_ready = 1'b0; in_valid = 1'b1; in_state = {4{$urandom}};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_ready: got %b expected 0", in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_round, out_state} !== {1'b1, held_round, held_state}) begin
                errors++;
                $display("[TB] FAIL bp_hold: got r=%0d s=%h expected r=%0d s=%h", out_round, out_state, held_round, held_state);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_round, out_state} !== {4'd1, in_state ^ rks[1]}) begin
            errors++;
            $display("[TB] FAIL bp_release: got r=%0d s=%h expected r=1 s=%h", out_round, out_state, in_state ^ rks[1]);
        end
    endtask

    task automatic test_abort();
        logic [127:0] new_key;
        for (int i = 0; i < 11 && m_round != 5; i++) begin
            in_valid = 1'b1; in_state = {4{$urandom}};
            tick();
        end
        checks++;
        if (out_round !== 4'd4) begin
            errors++;
            $display("[TB] FAIL abort_setup: got round %0d expected 4", out_round);
        end
        new_key = {4{$urandom}};
        key_load = 1'b1; key_in = new_key; in_valid = 1'b1; in_state = {4{$urandom}};
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_ready: got %b expected 0", in_ready);
        end
        tick();
        key_load = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_drop: got valid %b expected 0", out_valid);
        end
        in_state = {4{$urandom}};
        tick();
        checks++;
        if ({out_valid, out_round, out_state} !== {1'b1, 4'd0, in_state ^ new_key}) begin
            errors++;
            $display("[TB] FAIL abort_newkey: got r=%0d s=%h expected r=0 s=%h", out_round, out_state, in_state ^ new_key);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 11 && m_round != 7; i++) begin
            in_valid = 1'b1; in_state = {4{$urandom}};
            tick();
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_round, out_last, out_state, in_ready} !== 135'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b r=%0d l=%b s=%h rdy=%b expected zero",
                     out_valid, out_round, out_last, out_state, in_ready);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_state = {4{$urandom}};
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle: got rdy=%b v=%b expected 0 0", in_ready, out_valid);
            end
            tick();
        end
        key_load = 1'b1; key_in = {4{$urandom}};
        tick();
        key_load = 1'b0; in_state = {4{$urandom}};
        tick();
        checks++;
        if ({out_valid, out_round, out_state} !== {1'b1, 4'd0, in_state ^ key_in}) begin
            errors++;
            $display("[TB] FAIL post_reset_beat: got r=%0d s=%h expected r=0 s=%h", out_round, out_state, in_state ^ key_in);
        end
    endtask

    task automatic test_random_stream();
        key_load = 1'b1; key_in = {4{$urandom}};
        tick();
        for (int c = 0; c < 300; c++) begin
            key_load  = ($urandom_range(0, 39) == 0);
            key_in    = {4{$urandom}};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_state  = {4{$urandom}};
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++;
                $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, in_ready, exp_ready());
            end
            tick();
            checks++;
            if ({out_valid, out_round, out_last, out_state} !== {m_ov, m_or, m_ol, m_os}) begin
                errors++;
                $display("[TB] FAIL rnd_out c%0d: got v=%b r=%0d l=%b s=%h expected v=%b r=%0d l=%b s=%h",
                         c, out_valid, out_round, out_last, out_state, m_ov, m_or, m_ol, m_os);
            end
        end
        key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_key_schedule();
        test_wrap();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Sequential AddRoundKey stage of the iterative AES-128 encryption datapath. Sits directly downstream of the MixColumns stage and consumes its 16-byte state.
- Holds the cipher key and expands round keys on the fly, one round per accepted beat. XORs each incoming state with the key for the current round.
- Presents the result on a registered valid/ready output to the next round's SubBytes input, or to the ciphertext sink after round 10.

Parameters:
- NR, 10, number of AES rounds; round keys 0..NR are produced (AES-128 only; other values unsupported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  one-cycle strobe; capture key_in as the cipher key
- key_in  input  128  cipher key; packed [15:0][7:0], byte 0 (first FIPS-197 byte) in bits [7:0]
- in_valid  input  1  in_state is valid
- in_ready  output  1  stage can accept a beat this cycle
- in_state  input  128  state from MixColumns (or plaintext for round 0); byte i = column i/4, row i%4
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  in_state XOR round key
- out_round  output  4  round index (0..NR) applied to out_state
- out_last  output  1  out_state is the final (round NR) result, i.e. ciphertext

Behaviour:
- Reset (async assert, sync release): key_valid=0, round=0, rk=0, key0=0, out_valid=0, out_state=0, out_round=0, out_last=0. in_ready=0 while key_valid=0.
- key_load:
  - key0<=key_in; rk<=key_in; round<=0; key_valid<=1; out_valid<=0.
  - Has priority over everything in the same cycle. Any beat offered that cycle is not accepted, and in_ready is forced to 0.
  - Mid-block, it aborts the block: the pending output is dropped and the next accepted beat is round 0 under the new key.
- in_ready = key_valid & !key_load & (!out_valid | out_ready). Combinational; it is a one-entry pipeline register, so full throughput of 1 beat/cycle is sustained under out_ready=1.
- Accept (in_valid & in_ready), all registered:
  - out_state<=in_state^rk; out_round<=round; out_last<=(round==NR); out_valid<=1.
  - If round==NR: round<=0 and rk<=key0 (wrap to the next block).
  - Otherwise: round<=round+1 and rk<=next_rk(rk, rcon[round+1]).
- Output:
  - Latency is 1 cycle from accept to out_valid.
  - out_valid clears on out_ready when no new accept occurs in that cycle.
  - out_state, out_round and out_last hold stable while out_valid & !out_ready.
- next_rk, with w0..w3 = bytes 0-3, 4-7, 8-11, 12-15:
  - t = SubWord(RotWord(w3)). RotWord: new byte0 = old byte1, byte1 = byte2, byte2 = byte3, byte3 = byte0.
  - SubWord uses 4 forward AES S-box lookups (the team's existing S-box module).
  - t.byte0 ^= rcon.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. It is a combinational function of the round counter; no stored table state.
- The round counter never exceeds NR, and wrap is exact.
- in_valid while key_valid=0 is ignored, with no state change.
- Key expansion adds no latency; rk for the next beat is ready the cycle after accept.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and random inputs. Require out_valid=0, out_state=0, in_ready=0. Deassert rst_n and keep in_ready=0 until key_load.
- Key schedule, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: load the key, then stream 11 all-zero beats with out_ready=1. Required:
  - round 0 out = 2b7e1516…4f3c
  - round 1 out = a0fafe1788542cb123a339392a6c7605
  - round 10 out = d014f9a8c9ee2589e13f0cc8b6630ca6, with out_last=1 only on this beat
  - one beat per cycle
- Wrap: send a 12th zero beat. Require out_round=0 and out_state=2b7e…4f3c again.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Require in_ready=0, out_state/out_round frozen, and round not advanced. Release, and the next beat carries the next round.
- Abort: key_load with a new key after round 4 is accepted, with in_valid=1 in the same cycle. Require the beat not accepted and out_valid=0 next cycle. The next accepted beat gives out_round=0 and out_state=in_state^new key.
- Async reset mid-stream: pulse rst_n low between clock edges at round 6. Require outputs zero immediately and key_valid=0 (in_ready=0) until a new key_load.
